ck_energy_stage: RTL and testbench
==================================

Name: ck_energy_stage

Overview:
- One pipelined stage of the sidelobe-energy engine for low-autocorrelation binary sequence search.
- Computes the aperiodic autocorrelation C_k of two aligned bit vectors: a is the sequence, b is the sequence shifted by k, so only the overlapping W bits are applied.
- Outputs C_k, and separately adds C_k squared to a running energy carried in from the previous stage.
- Instances are chained, one per shift k, so the energy output of one stage feeds the energy input of the next.

Parameters:
- SEQ_WIDTH, 8, overlap width W in bits. Legal range 1..127.
- STAGE_WIDTH, 20, chunk size in bits for the first-stage partial popcounts. Any value ≥1 is legal; if ≥ SEQ_WIDTH there is a single chunk.
- E_WIDTH, 20, width of the energy input and output.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous, active-high reset.
- a, input, SEQ_WIDTH, sequence bits; bit value 1 means +1, 0 means -1.
- b, input, SEQ_WIDTH, shifted sequence bits, aligned bit-for-bit with a.
- e_in, input, E_WIDTH, unsigned energy accumulated by earlier stages.
- ck, output, 8, signed two's-complement C_k.
- e_out, output, E_WIDTH, unsigned value e_in + ck*ck.

Behaviour:
- Correlation arithmetic:
  - Each bit position contributes +1 if a[i] equals b[i] and -1 otherwise.
  - ck = W - 2*popcount(a XOR b), giving a range of -W..+W. Sign-extend or truncate the result to 8 bits.
- Correlation pipeline, 2 register stages:
  - Stage 1, at edge N: split a XOR b into ceil(W/STAGE_WIDTH) chunks of STAGE_WIDTH bits, the last chunk partial. Register each chunk's popcount.
  - Stage 2, at edge N+1: sum the chunk counts, form W - 2*sum, and register the result in ck.
  - Result: a/b sampled at edge N appears on ck after edge N+1.
  - Latency is always 2 cycles, independent of STAGE_WIDTH.
- Square-accumulate, 1 register stage:
  - At every edge, e_out <= e_in + ck*ck, using the ck register value present in that cycle.
  - ck*ck is unsigned, at most 16129, so it fits in 14 bits.
  - The addition wraps modulo 2^E_WIDTH unless the optional feature below is enabled.
- Chaining alignment:
  - e_in must be presented in the cycle that ck holds the matching result.
  - Overall: a/b at edge N, then e_in sampled at edge N+2, then e_out valid after edge N+2.
- The block is fully pipelined: a new a/b pair may be accepted every cycle. There is no handshake or stall.
- Reset:
  - While rst is sampled high, every register (chunk counts, ck, e_out) loads 0.
  - Reset overrides any data in flight; results entering before reset are discarded.
- After reset is released, outputs follow the inputs with the stated latencies.
  - Example: a=b=0 after release gives ck=+W two cycles later.
- Boundary conditions:
  - W=1: ck is ±1.
  - a==b: ck=+W.
  - a==~b: ck=-W.
  - STAGE_WIDTH not dividing W: the last chunk is partial and its unused bits count as 0.
- No combinational path from any input to any output.

Optional Feature:
- Macro: CKE_SATURATE_EN.
- Defined: if e_in + ck*ck exceeds 2^E_WIDTH - 1, e_out saturates to all ones.
- Not defined: the addition wraps modulo 2^E_WIDTH.
- Reset and latency are identical in both builds.

Decomposition:
- Shared package cke_pkg holds:
  - CK_WIDTH = 8;
  - typedef ck_t (signed logic [7:0]);
  - function sq_ck(ck_t), returning the unsigned 14-bit square.
- One natural sub-module, sq_acc:
  - Inputs clk, rst, ck, e_in; output e_out.
  - One register stage, and it contains the saturation option.
- The popcount chunking stays in the top module.

Test Plan:
- Defaults (W=8), with rst then released and a=8'hFF, b=8'hFF held: ck=+8 two cycles after the first sample. With e_in=0, e_out=64 one cycle later.
- a=8'hAA, b=8'h55: ck=-8. With e_in=100 aligned to ck, e_out=164.
- a=8'hF0, b=8'h78 (XOR=8'h88, popcount 2): ck=+4. With e_in=10, e_out=26.
- Back-to-back vectors on consecutive cycles (FF/FF, AA/55, F0/78): ck sequence +8, -8, +4 on consecutive cycles. Confirms full throughput and fixed latency.
- STAGE_WIDTH=3, W=8 (chunks 3, 3, 2), a=8'h0F, b=8'h00: ck=0, with latency still 2.
- Wrap/saturate and reset:
  - E_WIDTH=6, e_in=60, ck=+8 (sum 124): e_out=60 without CKE_SATURATE_EN (wrap), and 63 with it.
  - Asserting rst mid-stream: ck=0 and e_out=0 on the next cycle.

Source files
------------

// File: rtl/ck_energy_stage_pkg.sv
// cke_pkg: shared correlation types and the C_k squaring helper.
package cke_pkg;
  localparam int CK_WIDTH = 8;
  typedef logic signed [CK_WIDTH-1:0] ck_t;
  function automatic logic [13:0] sq_ck(input ck_t c);
    logic [13:0] m;
    m = 14'(c[7] ? -c : c);
    return m * m;
  endfunction
endpackage

// File: rtl/ck_energy_stage_if.sv
// ck_energy_stage_if: sequence pair, energy chain and C_k signals of one stage.
interface ck_energy_stage_if #(parameter int SEQ_WIDTH = 8, parameter int E_WIDTH = 20);
  import cke_pkg::*;
  logic [SEQ_WIDTH-1:0] a;
  logic [SEQ_WIDTH-1:0] b;
  logic [E_WIDTH-1:0] e_in;
  logic [E_WIDTH-1:0] e_out;
  ck_t ck;
  modport master(output a, b, e_in, input ck, e_out);
  modport slave(input a, b, e_in, output ck, e_out);
endinterface

// File: rtl/ck_energy_stage_sq_acc.sv
// sq_acc: registers e_in + ck*ck; saturates instead of wrapping when CKE_SATURATE_EN is defined.
module sq_acc
  import cke_pkg::*;
#(
  parameter int E_WIDTH = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  ck_t                ck,
  input  logic [E_WIDTH-1:0] e_in,
  output logic [E_WIDTH-1:0] e_out
);
  localparam int SW = (E_WIDTH > 14 ? E_WIDTH : 14) + 1;
  logic [SW-1:0] sum;
  logic [E_WIDTH-1:0] e_nxt;
  assign sum = SW'(e_in) + SW'(sq_ck(ck));
`ifdef CKE_SATURATE_EN
  assign e_nxt = (sum > SW'({E_WIDTH{1'b1}})) ? '1 : sum[E_WIDTH-1:0];
`else
  assign e_nxt = sum[E_WIDTH-1:0];
`endif
  always_ff @(posedge clk)
    e_out <= rst ? '0 : e_nxt;
endmodule

// File: rtl/ck_energy_stage.sv
// ck_energy_stage: chunked-popcount C_k pipeline (2 stages) feeding a square-accumulate stage.
// Optional CKE_SATURATE_EN (in sq_acc) saturates e_out instead of wrapping.
module ck_energy_stage
  import cke_pkg::*;
#(
  parameter int SEQ_WIDTH   = 8,
  parameter int STAGE_WIDTH = 20,
  parameter int E_WIDTH     = 20
) (
  input logic clk,
  input logic rst,
  ck_energy_stage_if.slave bus
);
  localparam int NC = (SEQ_WIDTH + STAGE_WIDTH - 1) / STAGE_WIDTH;
  // Zero padding makes the partial last chunk count its unused bits as 0.
  logic [NC*STAGE_WIDTH-1:0] xp;
  logic [7:0] pc [NC];
  logic [7:0] cnt [NC];
  logic [7:0] sum;
  ck_t ck_q;
  assign xp = (NC*STAGE_WIDTH)'(bus.a ^ bus.b);
  always_comb begin
    for (int c = 0; c < NC; c++) begin
      pc[c] = '0;
      for (int j = 0; j < STAGE_WIDTH; j++) pc[c] = pc[c] + 8'(xp[c*STAGE_WIDTH+j]);
    end
  end
  always_comb begin
    sum = '0;
    for (int c = 0; c < NC; c++) sum = sum + cnt[c];
  end
  always_ff @(posedge clk) begin
    for (int c = 0; c < NC; c++) cnt[c] <= rst ? '0 : pc[c];
    ck_q <= rst ? '0 : ck_t'(8'(SEQ_WIDTH) - (sum << 1));
  end
  assign bus.ck = ck_q;
  sq_acc #(.E_WIDTH(E_WIDTH)) u_sq_acc (
    .clk  (clk),
    .rst  (rst),
    .ck   (ck_q),
    .e_in (bus.e_in),
    .e_out(bus.e_out)
  );
endmodule

// File: tb/tb_ck_energy_stage.sv
// tb_ck_energy_stage: scoreboard bench over three configurations (W=8 default, W=8/chunk 3/E=6, W=1).
module tb_ck_energy_stage;
  localparam bit SAT =
`ifdef CKE_SATURATE_EN
    1'b1;
`else
    1'b0;
`endif
  typedef struct {int due; int v0; int v1; int v2;} exp_t;
  logic clk = 0;
  logic rst = 1;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  exp_t qck[$];
  exp_t qe[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ck_energy_stage_if #(.SEQ_WIDTH(8), .E_WIDTH(20)) i0 ();
  ck_energy_stage_if #(.SEQ_WIDTH(8), .E_WIDTH(6))  i1 ();
  ck_energy_stage_if #(.SEQ_WIDTH(1), .E_WIDTH(20)) i2 ();
  ck_energy_stage #(.SEQ_WIDTH(8), .STAGE_WIDTH(20), .E_WIDTH(20)) u0 (.clk(clk), .rst(rst), .bus(i0));
  ck_energy_stage #(.SEQ_WIDTH(8), .STAGE_WIDTH(3),  .E_WIDTH(6))  u1 (.clk(clk), .rst(rst), .bus(i1));
  ck_energy_stage #(.SEQ_WIDTH(1), .STAGE_WIDTH(20), .E_WIDTH(20)) u2 (.clk(clk), .rst(rst), .bus(i2));

  int va [7]  = '{'hFF, 'hAA, 'hF0, 'h0F, 'h00, 'h3C, 'h81};
  int vb [7]  = '{'hFF, 'h55, 'h78, 'h00, 'h00, 'hC3, 'h01};
  int ve0[7]  = '{0, 100, 10, 1, 'hFFFFF, 7, 0};
  int ve1[7]  = '{60, 0, 3, 10, 0, 0, 20};
  int ve2[7]  = '{5, 0, 7, 0, 0, 2, 0};
  int xck[7]  = '{8, -8, 4, 0, 8, -8, 6};
  int xw1[7]  = '{1, -1, 1, -1, 1, -1, 1};
  int xe0[7]  = '{64, 164, 26, 1, SAT ? 'hFFFFF : 63, 71, 36};
  int xe1[7]  = '{SAT ? 63 : 60, SAT ? 63 : 0, 19, 10, SAT ? 63 : 0, SAT ? 63 : 0, 56};
  int xe2[7]  = '{6, 1, 8, 1, 1, 3, 1};

  task automatic chk(string n, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", n, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ab(int a, int b);
    int t;
    t = a;
    i0.a = 8'(a);
    i0.b = 8'(b);
    i1.a = 8'(a);
    i1.b = 8'(b);
    i2.a = t[0];
    t = b;
    i2.b = t[0];
  endtask

  task automatic drive_e(int e0, int e1, int e2);
    i0.e_in = 20'(e0);
    i1.e_in = 6'(e1);
    i2.e_in = 20'(e2);
  endtask

  always @(negedge clk) begin
    while (qck.size() > 0 && qck[0].due <= cyc) begin
      if (qck[0].due < cyc) chk("ck_missed", cyc, qck[0].due);
      else begin
        chk("ck_w8", int'(i0.ck), qck[0].v0);
        chk("ck_chunk3", int'(i1.ck), qck[0].v1);
        chk("ck_w1", int'(i2.ck), qck[0].v2);
      end
      void'(qck.pop_front());
    end
    while (qe.size() > 0 && qe[0].due <= cyc) begin
      if (qe[0].due < cyc) chk("e_missed", cyc, qe[0].due);
      else begin
        chk("e_out_w8", int'(i0.e_out), qe[0].v0);
        chk("e_out_e6", int'(i1.e_out), qe[0].v1);
        chk("e_out_w1", int'(i2.e_out), qe[0].v2);
      end
      void'(qe.pop_front());
    end
  end

  initial begin
    int c;
    drive_ab(0, 0);
    drive_e(0, 0, 0);
    rst = 1;
    repeat (3) step();
    qck.push_back('{cyc, 0, 0, 0});
    qe.push_back('{cyc, 0, 0, 0});
    rst = 0;
    for (int i = 0; i < 9; i++) begin
      if (i < 7) begin
        drive_ab(va[i], vb[i]);
        qck.push_back('{cyc + 2, xck[i], xck[i], xw1[i]});
        qe.push_back('{cyc + 3, xe0[i], xe1[i], xe2[i]});
      end else drive_ab(0, 0);
      if (i >= 2) drive_e(ve0[i-2], ve1[i-2], ve2[i-2]);
      else drive_e(0, 0, 0);
      step();
    end
    drive_e(0, 0, 0);
    repeat (3) step();
    c = cyc;
    drive_ab('hAA, 'h55);
    step();
    rst = 1;
    drive_e(5, 5, 5);
    step();
    qck.push_back('{c + 2, 0, 0, 0});
    qe.push_back('{c + 2, 0, 0, 0});
    rst = 0;
    drive_ab(0, 0);
    drive_e(0, 0, 0);
    qck.push_back('{c + 4, 8, 8, 1});
    qe.push_back('{c + 5, 64, SAT ? 63 : 0, 1});
    repeat (5) step();
    if (qck.size() + qe.size() != 0) chk("drain", qck.size() + qe.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
